// File: rtl/rs_t1_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module   : rs_t1_stream_decoder
// Function : Streaming single-symbol-error (t=1) Reed-Solomon decoder over
//            GF(2^SYMBOL_WIDTH): syndrome load, divider-free search, replay.
// Revision : 1.0 - initial release
// ============================================================================
module rs_t1_stream_decoder #(
    parameter int SYMBOL_WIDTH = 3,
    parameter int PRIM_POLY    = 11,
    parameter int N            = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SYMBOL_WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SYMBOL_WIDTH-1:0] out_data,
    output logic                    out_last,
    output logic [1:0]              status
);

    localparam int                    CW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [SYMBOL_WIDTH:0] c_POLY = (SYMBOL_WIDTH + 1)'(PRIM_POLY);
    localparam logic [CW-1:0]         c_LAST = CW'(N - 1);

    localparam logic [1:0] c_ST_LOAD   = 2'd0;
    localparam logic [1:0] c_ST_CHECK  = 2'd1;
    localparam logic [1:0] c_ST_SEARCH = 2'd2;
    localparam logic [1:0] c_ST_EMIT   = 2'd3;

    localparam logic [1:0] c_NO_ERR    = 2'd0;
    localparam logic [1:0] c_CORRECTED = 2'd1;
    localparam logic [1:0] c_UNCORR    = 2'd2;

    function automatic logic [SYMBOL_WIDTH-1:0] f_mul_alpha(input logic [SYMBOL_WIDTH-1:0] x);
        return {x[SYMBOL_WIDTH-2:0], 1'b0} ^
               (x[SYMBOL_WIDTH-1] ? c_POLY[SYMBOL_WIDTH-1:0] : '0);
    endfunction

    // The primitive polynomial has a constant term, so adding it clears bit 0
    // and makes the division by x exact.
    function automatic logic [SYMBOL_WIDTH-1:0] f_mul_alpha_inv(input logic [SYMBOL_WIDTH-1:0] x);
        logic [SYMBOL_WIDTH:0] v_tmp;
        v_tmp = {1'b0, x} ^ (x[0] ? c_POLY : '0);
        return v_tmp[SYMBOL_WIDTH:1];
    endfunction

    logic [1:0]              r_state, w_next_state;
    logic [CW-1:0]           r_cnt, r_k, r_err_pos;
    logic [SYMBOL_WIDTH-1:0] r_s1, r_s2, r_t, r_u, r_err_val;
    logic [1:0]              r_status;
    logic [SYMBOL_WIDTH-1:0] r_buf [0:N-1];

    logic [SYMBOL_WIDTH-1:0] w_s1_base, w_s2_base;
    logic [CW-1:0]           w_pos;
    logic                    w_match, w_k_last, w_cnt_last;

    assign w_s1_base  = (r_cnt == '0) ? '0 : r_s1;
    assign w_s2_base  = (r_cnt == '0) ? '0 : r_s2;
    assign w_pos      = c_LAST - r_cnt;
    assign w_match    = (r_t == r_s2);
    assign w_k_last   = (r_k == c_LAST);
    assign w_cnt_last = (r_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (reset) r_state <= c_ST_LOAD;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_LOAD:   if (in_valid && w_cnt_last) w_next_state = c_ST_CHECK;
            c_ST_CHECK:  w_next_state = (r_s1 == '0 || r_s2 == '0) ? c_ST_EMIT : c_ST_SEARCH;
            c_ST_SEARCH: if (w_match || w_k_last) w_next_state = c_ST_EMIT;
            default:     if (out_ready && w_cnt_last) w_next_state = c_ST_LOAD;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == c_ST_LOAD);
        out_valid = (r_state == c_ST_EMIT);
        out_last  = out_valid && w_cnt_last;
        out_data  = '0;
        if (out_valid) begin
            out_data = r_buf[r_cnt] ^
                       ((r_status == c_CORRECTED && w_pos == r_err_pos) ? r_err_val : '0);
        end
        status    = r_status;
    end

    always_ff @(posedge clk) begin
        if (r_state == c_ST_LOAD && in_valid) r_buf[r_cnt] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_k       <= '0;
            r_err_pos <= '0;
            r_s1      <= '0;
            r_s2      <= '0;
            r_t       <= '0;
            r_u       <= '0;
            r_err_val <= '0;
            r_status  <= c_NO_ERR;
        end else begin
            case (r_state)
                c_ST_LOAD: if (in_valid) begin
                    r_s1  <= f_mul_alpha(w_s1_base) ^ in_data;
                    r_s2  <= f_mul_alpha(f_mul_alpha(w_s2_base)) ^ in_data;
                    r_cnt <= w_cnt_last ? '0 : r_cnt + CW'(1);
                end
                c_ST_CHECK: begin
                    if (r_s1 == '0 && r_s2 == '0) begin
                        r_status <= c_NO_ERR;
                    end else if (r_s1 == '0 || r_s2 == '0) begin
                        r_status <= c_UNCORR;
                    end else begin
                        r_t <= r_s1;
                        r_u <= r_s1;
                        r_k <= '0;
                    end
                end
                // T walks S1*alpha^k towards S2 while U tracks S1*alpha^-k,
                // which equals the error value exactly at the match.
                c_ST_SEARCH: begin
                    if (w_match) begin
                        r_err_pos <= r_k;
                        r_err_val <= r_u;
                        r_status  <= c_CORRECTED;
                    end else if (w_k_last) begin
                        r_status  <= c_UNCORR;
                    end else begin
                        r_t <= f_mul_alpha(r_t);
                        r_u <= f_mul_alpha_inv(r_u);
                        r_k <= r_k + CW'(1);
                    end
                end
                default: if (out_ready) r_cnt <= w_cnt_last ? '0 : r_cnt + CW'(1);
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rs_t1_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs_t1_stream_decoder
// Function : Randomised self-checking bench for rs_t1_stream_decoder against a
//            GF-arithmetic reference decoder, in two field configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rs_t1_stream_decoder;

    logic       clk = 1'b0;
    logic       reset, sel, drv_valid, drv_oready;
    logic [7:0] drv_data;

    logic       d0_in_ready, d0_out_valid, d0_out_last;
    logic [2:0] d0_out_data;
    logic [1:0] d0_status;
    logic       d1_in_ready, d1_out_valid, d1_out_last;
    logic [3:0] d1_out_data;
    logic [1:0] d1_status;

    logic       mon_in_ready, mon_out_valid, mon_out_last;
    logic [7:0] mon_out_data;
    logic [1:0] mon_status;

    always #5 clk = ~clk;

    rs_t1_stream_decoder #(.SYMBOL_WIDTH(3), .PRIM_POLY(11), .N(7)) u_dut0 (
        .clk(clk), .reset(reset),
        .in_valid(drv_valid & ~sel), .in_ready(d0_in_ready), .in_data(drv_data[2:0]),
        .out_valid(d0_out_valid), .out_ready(drv_oready), .out_data(d0_out_data),
        .out_last(d0_out_last), .status(d0_status)
    );

    rs_t1_stream_decoder #(.SYMBOL_WIDTH(4), .PRIM_POLY(19), .N(15)) u_dut1 (
        .clk(clk), .reset(reset),
        .in_valid(drv_valid & sel), .in_ready(d1_in_ready), .in_data(drv_data[3:0]),
        .out_valid(d1_out_valid), .out_ready(drv_oready), .out_data(d1_out_data),
        .out_last(d1_out_last), .status(d1_status)
    );

    assign mon_in_ready  = sel ? d1_in_ready  : d0_in_ready;
    assign mon_out_valid = sel ? d1_out_valid : d0_out_valid;
    assign mon_out_last  = sel ? d1_out_last  : d0_out_last;
    assign mon_out_data  = sel ? {4'b0, d1_out_data} : {5'b0, d0_out_data};
    assign mon_status    = sel ? d1_status    : d0_status;

    int cur_m, cur_poly, cur_n;
    int frm [15];
    int exp_out [15];
    int exp_status, exp_lat;
    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs != exp_v) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int gmul(input int a, input int b);
        int r = 0;
        int x = a;
        for (int i = 0; i < cur_m; i++) begin
            if (b[i]) r ^= x;
            x = x << 1;
            if ((x & (1 << cur_m)) != 0) x ^= cur_poly;
        end
        return r;
    endfunction

    function automatic int gpow(input int a, input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = gmul(r, a);
        return r;
    endfunction

    function automatic int gdiv(input int a, input int b);
        for (int x = 0; x < (1 << cur_m); x++)
            if (gmul(x, b) == a) return x;
        return 0;
    endfunction

    // Syndrome p: evaluate the received polynomial at alpha^p (frm[0] = r_{N-1}).
    function automatic int synd(input int p);
        int s = 0;
        for (int i = 0; i < cur_n; i++)
            s ^= gmul(frm[cur_n-1-i], gpow(gpow(2, p), i));
        return s;
    endfunction

    task automatic model();
        int s1, s2;
        s1 = synd(1);
        s2 = synd(2);
        for (int i = 0; i < cur_n; i++) exp_out[i] = frm[i];
        if (s1 == 0 && s2 == 0) begin
            exp_status = 0; exp_lat = 2;
        end else if (s1 == 0 || s2 == 0) begin
            exp_status = 2; exp_lat = 2;
        end else begin
            exp_status = 2; exp_lat = cur_n + 2;
            for (int j = 0; j < cur_n; j++) begin
                if (gmul(s1, gpow(2, j)) == s2) begin
                    exp_out[cur_n-1-j] = frm[cur_n-1-j] ^ gdiv(s1, gpow(2, j));
                    exp_status = 1; exp_lat = 3 + j;
                    break;
                end
            end
        end
    endtask

    // Random message symbols, then solve the two check symbols so S1 = S2 = 0.
    task automatic make_codeword(input int n_err);
        int a1, a2, r1;
        for (int i = 0; i < cur_n - 2; i++) frm[i] = int'($urandom_range(0, (1 << cur_m) - 1));
        frm[cur_n-2] = 0;
        frm[cur_n-1] = 0;
        a1 = synd(1);
        a2 = synd(2);
        r1 = gdiv(a1 ^ a2, 6);
        frm[cur_n-2] = r1;
        frm[cur_n-1] = a1 ^ gmul(r1, 2);
        for (int e = 0; e < n_err; e++) begin
            int pos;
            pos = int'($urandom_range(0, cur_n - 1));
            frm[pos] ^= int'($urandom_range(1, (1 << cur_m) - 1));
        end
    endtask

    task automatic send_frame(input bit gaps);
        for (int i = 0; i < cur_n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            drv_valid = 1'b1;
            drv_data  = 8'(frm[i]);
            chk("in_ready_load", int'(mon_in_ready), 1);
            @(posedge clk);
            @(negedge clk);
            drv_valid = 1'b0;
        end
    endtask

    task automatic check_latency();
        int lat = 1;
        while (!mon_out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, exp_lat);
    endtask

    task automatic recv_frame(input bit stall, input int count);
        for (int i = 0; i < count; i++) begin
            int w = 0;
            while (!mon_out_valid && w < 20) begin
                @(negedge clk);
                w++;
            end
            chk("out_valid", int'(mon_out_valid), 1);
            if (stall && i == 3) begin
                drv_oready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("hold_valid", int'(mon_out_valid), 1);
                    chk("hold_data", int'(mon_out_data), exp_out[i]);
                    chk("hold_last", int'(mon_out_last), 0);
                    chk("hold_status", int'(mon_status), exp_status);
                end
                drv_oready = 1'b1;
            end
            chk("out_data", int'(mon_out_data), exp_out[i]);
            chk("out_last", int'(mon_out_last), int'(i == cur_n - 1));
            chk("status", int'(mon_status), exp_status);
            chk("in_ready_emit", int'(mon_in_ready), 0);
            @(negedge clk);
        end
        if (count == cur_n) begin
            chk("post_out_valid", int'(mon_out_valid), 0);
            chk("post_in_ready", int'(mon_in_ready), 1);
        end
    endtask

    task automatic run_frame(input bit gaps, input bit stall);
        model();
        send_frame(gaps);
        check_latency();
        recv_frame(stall, cur_n);
    endtask

    task automatic set_frame7(input int a, b, c, d, e, f, g);
        frm[0] = a; frm[1] = b; frm[2] = c; frm[3] = d;
        frm[4] = e; frm[5] = f; frm[6] = g;
    endtask

    initial begin
        reset = 1'b1; sel = 1'b0; drv_valid = 1'b0; drv_oready = 1'b1; drv_data = '0;
        cur_m = 3; cur_poly = 11; cur_n = 7;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", int'(mon_out_valid), 0);
        chk("rst_in_ready", int'(mon_in_ready), 1);
        chk("rst_out_last", int'(mon_out_last), 0);
        chk("rst_out_data", int'(mon_out_data), 0);
        chk("rst_status", int'(mon_status), 0);
        reset = 1'b0;

        set_frame7(0, 0, 0, 0, 0, 0, 0); run_frame(1'b0, 1'b0);
        set_frame7(0, 0, 0, 0, 1, 0, 0); run_frame(1'b0, 1'b0);
        set_frame7(0, 0, 0, 0, 0, 0, 3); run_frame(1'b0, 1'b1);
        set_frame7(0, 0, 0, 0, 0, 1, 2); run_frame(1'b1, 1'b0);

        for (int f = 0; f < 24; f++) begin
            make_codeword(int'($urandom_range(0, 2)));
            run_frame(1'(f % 2), 1'($urandom_range(0, 1)));
        end

        // Abort a frame mid-replay; only the following clean frame may appear.
        set_frame7(0, 0, 0, 0, 1, 0, 0);
        model();
        send_frame(1'b0);
        check_latency();
        recv_frame(1'b0, 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_out_valid", int'(mon_out_valid), 0);
        chk("mid_rst_in_ready", int'(mon_in_ready), 1);
        chk("mid_rst_status", int'(mon_status), 0);
        make_codeword(0);
        run_frame(1'b1, 1'b0);

        sel = 1'b0;
        @(negedge clk);
        sel = 1'b1; cur_m = 4; cur_poly = 19; cur_n = 15;
        for (int i = 0; i < 15; i++) frm[i] = 0;
        frm[15-1-11] = 9;
        run_frame(1'b0, 1'b0);
        chk("cfg2_status", int'(mon_status), 1);
        for (int f = 0; f < 10; f++) begin
            make_codeword(int'($urandom_range(0, 2)));
            run_frame(1'b1, 1'(f % 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
